// File: rtl/te_rr_stream_mux.sv
// N-to-1 valid/ready stream mux with round-robin arbitration, burst lock, fixed-select
// bypass and a registered output stage.
module te_rr_stream_mux #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHANNEL_NUM = 4,
    parameter int SEL_WIDTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst_b,
    input  logic                              fixed_mode,
    input  logic [SEL_WIDTH-1:0]              fixed_sel,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] data_in,
    input  logic [CHANNEL_NUM-1:0]            valid_in,
    input  logic [CHANNEL_NUM-1:0]            last_in,
    output logic [CHANNEL_NUM-1:0]            ready_out,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic [SEL_WIDTH-1:0]              sel_out,
    output logic                              last_out,
    output logic                              valid_out,
    input  logic                              ready_in
);

    typedef enum logic {StIdle, StLock} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [SEL_WIDTH-1:0]  r_ptr;
    logic [SEL_WIDTH-1:0]  w_ptr_next;
    logic [SEL_WIDTH-1:0]  r_lock_ch;

    logic [DATA_WIDTH-1:0] r_data;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic                  r_last;
    logic                  r_valid;

    logic [SEL_WIDTH:0]    w_idx;
    logic [SEL_WIDTH-1:0]  w_rr_gnt;
    logic                  w_rr_found;
    logic [SEL_WIDTH-1:0]  w_gnt;
    logic                  w_gnt_en;
    logic [DATA_WIDTH-1:0] w_gnt_data;
    logic                  w_gnt_last;
    logic                  w_can_load;
    logic                  w_xfer;

    assign w_can_load = !r_valid || ready_in;
    assign w_xfer     = |(ready_out & valid_in);

    // First valid channel at or after the pointer, wrapping modulo CHANNEL_NUM.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_gnt   = '0;
        w_idx      = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            w_idx = {1'b0, r_ptr} + (SEL_WIDTH + 1)'(i);
            if (w_idx >= (SEL_WIDTH + 1)'(CHANNEL_NUM)) begin
                w_idx = w_idx - (SEL_WIDTH + 1)'(CHANNEL_NUM);
            end
            if (!w_rr_found && valid_in[w_idx[SEL_WIDTH-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_gnt   = w_idx[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_gnt    = '0;
        w_gnt_en = 1'b0;
        if (fixed_mode) begin
            w_gnt    = fixed_sel;
            w_gnt_en = (int'(fixed_sel) < CHANNEL_NUM);
        end else if (r_state == StLock) begin
            w_gnt    = r_lock_ch;
            w_gnt_en = 1'b1;
        end else begin
            w_gnt    = w_rr_gnt;
            w_gnt_en = w_rr_found;
        end
    end

    always_comb begin
        w_gnt_data = '0;
        w_gnt_last = 1'b0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            if (w_gnt == SEL_WIDTH'(k)) begin
                w_gnt_data = data_in[k*DATA_WIDTH +: DATA_WIDTH];
                w_gnt_last = last_in[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_lock_ch <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            if (r_state == StIdle && w_state_next == StLock) begin
                r_lock_ch <= w_gnt;
            end
        end
    end

    // Fixed mode abandons any lock on the next edge.
    always_comb begin
        w_state_next = r_state;
        if (fixed_mode) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: if (w_xfer && !w_gnt_last) w_state_next = StLock;
                StLock: if (w_xfer && w_gnt_last)  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_ptr_next = r_ptr;
        if (!fixed_mode && w_xfer && w_gnt_last) begin
            w_ptr_next = (int'(w_gnt) == CHANNEL_NUM - 1) ? '0 : w_gnt + 1'b1;
        end
    end

    always_comb begin
        ready_out = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            ready_out[k] = rst_b && w_gnt_en && w_can_load && (w_gnt == SEL_WIDTH'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_last  <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_gnt_data;
            r_sel   <= w_gnt;
            r_last  <= w_gnt_last;
        end else if (ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign sel_out   = r_sel;
    assign last_out  = r_last;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_te_rr_stream_mux.sv
// Scoreboard bench for te_rr_stream_mux: directed phases push expected beats, a negedge
// monitor pops and compares every output transfer.
module tb_te_rr_stream_mux;
    localparam int DW  = 32;
    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int NB  = 5;
    localparam int SWB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_b;
    logic            fixed_mode;
    logic [SW-1:0]   fixed_sel;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    valid_in, last_in, ready_out;
    logic [DW-1:0]   data_out;
    logic [SW-1:0]   sel_out;
    logic            last_out, valid_out, ready_in;

    logic             fixed_mode_b;
    logic [SWB-1:0]   fixed_sel_b;
    logic [NB*DW-1:0] data_b;
    logic [NB-1:0]    valid_b, last_b, ready_out_b;
    logic [DW-1:0]    data_out_b;
    logic [SWB-1:0]   sel_out_b;
    logic             last_out_b, valid_out_b, ready_in_b;

    te_rr_stream_mux #(.DATA_WIDTH(DW), .CHANNEL_NUM(N), .SEL_WIDTH(SW)) u_dut (
        .clk(clk), .rst_b(rst_b), .fixed_mode(fixed_mode), .fixed_sel(fixed_sel),
        .data_in(data_in), .valid_in(valid_in), .last_in(last_in), .ready_out(ready_out),
        .data_out(data_out), .sel_out(sel_out), .last_out(last_out), .valid_out(valid_out),
        .ready_in(ready_in)
    );

    // Five-channel instance so an out-of-range fixed_sel is representable.
    te_rr_stream_mux #(.DATA_WIDTH(DW), .CHANNEL_NUM(NB), .SEL_WIDTH(SWB)) u_dut_b (
        .clk(clk), .rst_b(rst_b), .fixed_mode(fixed_mode_b), .fixed_sel(fixed_sel_b),
        .data_in(data_b), .valid_in(valid_b), .last_in(last_b), .ready_out(ready_out_b),
        .data_out(data_out_b), .sel_out(sel_out_b), .last_out(last_out_b),
        .valid_out(valid_out_b), .ready_in(ready_in_b)
    );

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        mon_e;
    int           checks = 0;
    int           errors = 0;
    int           cnt[N], pos[N], blen[N], en[N];
    logic [N-1:0] acc;

    function automatic logic [DW-1:0] mk(input int k, input int n);
        return {16'hC0DE, k[7:0], n[7:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            data_in[k*DW +: DW] = mk(k, cnt[k]);
            last_in[k]          = (pos[k] == blen[k] - 1);
        end
    endtask

    task automatic set_blen(input int k, input int v);
        blen[k] = v;
        pos[k]  = 0;
        drive();
    endtask

    task automatic push(input int k, input logic last);
        beat_t b;
        b.sel  = SW'(k);
        b.data = mk(k, en[k]);
        b.last = last;
        exp_q.push_back(b);
        en[k]++;
    endtask

    // One clock: note which channels handshake, then advance their streams after the edge.
    task automatic tick();
        @(negedge clk);
        acc = valid_in & ready_out;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                cnt[k]++;
                pos[k] = (pos[k] + 1 == blen[k]) ? 0 : pos[k] + 1;
            end
        end
        drive();
    endtask

    always @(negedge clk) begin
        if (rst_b === 1'b1 && valid_out === 1'b1 && ready_in === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected sel=%0d data=%h last=%0d", sel_out, data_out,
                         last_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({sel_out, data_out, last_out} !== mon_e) begin
                    errors++;
                    $display("FAIL beat: got sel=%0d data=%h last=%0d expected sel=%0d data=%h last=%0d",
                             sel_out, data_out, last_out, mon_e.sel, mon_e.data, mon_e.last);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b      = 1'b0;
        ready_in   = 1'b1;
        fixed_mode = 1'b0;
        fixed_sel  = '0;
        valid_in   = '1;
        for (int k = 0; k < N; k++) begin
            cnt[k] = 0; pos[k] = 0; blen[k] = 1; en[k] = 0;
        end
        drive();
        fixed_mode_b = 1'b0;
        fixed_sel_b  = '0;
        valid_b      = '0;
        last_b       = '1;
        ready_in_b   = 1'b1;
        for (int k = 0; k < NB; k++) data_b[k*DW +: DW] = 32'hB000_0000 | k;

        // Reset with every channel valid
        repeat (3) begin
            tick();
            check("rst_valid", valid_out, 0);
            check("rst_ready", ready_out, 0);
        end

        // Round robin, single-beat bursts
        for (int i = 0; i < 8; i++) push(i % 4, 1'b1);
        rst_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_valid", valid_out, 1);
        end
        valid_in = '0;
        tick(); tick();
        check("rr_drained", exp_q.size(), 0);

        // Burst lock on ch2
        set_blen(2, 4);
        push(2, 0); push(2, 0); push(2, 0); push(2, 1);
        push(3, 1); push(0, 1); push(1, 1);
        valid_in = 4'b0100;
        tick();
        valid_in = '1;
        repeat (3) begin
            #1;
            check("lock_ready", ready_out, 4'b0100);
            tick();
        end
        repeat (3) tick();
        valid_in = '0;
        set_blen(2, 1);
        tick(); tick();
        check("lock_drained", exp_q.size(), 0);

        // Backpressure
        push(2, 1); push(3, 1); push(0, 1); push(1, 1); push(2, 1);
        valid_in = '1;
        tick();
        ready_in = 1'b0;
        repeat (5) begin
            #1;
            check("bp_ready", ready_out, 0);
            check("bp_hold", {valid_out, sel_out, data_out, last_out}, {1'b1, exp_q[0]});
            tick();
        end
        ready_in = 1'b1;
        repeat (4) tick();
        valid_in = '0;
        tick(); tick();
        check("bp_drained", exp_q.size(), 0);

        // Fixed mode on ch1
        push(1, 1); push(1, 1); push(1, 1); push(1, 1);
        fixed_mode = 1'b1;
        fixed_sel  = 2'd1;
        valid_in   = '1;
        #1;
        check("fix_ready", ready_out, 4'b0010);
        repeat (4) tick();
        valid_in   = '0;
        fixed_mode = 1'b0;
        tick(); tick();
        check("fix_drained", exp_q.size(), 0);

        // Out-of-range fixed_sel on the five-channel instance
        fixed_mode_b = 1'b1;
        fixed_sel_b  = 3'd1;
        valid_b      = '1;
        #1;
        check("b_ready", ready_out_b, 5'b00010);
        tick();
        check("b_beat", {valid_out_b, sel_out_b, data_out_b}, {1'b1, 3'd1, 32'hB000_0001});
        fixed_sel_b = 3'd5;
        #1;
        check("b_oor_ready5", ready_out_b, 0);
        tick();
        check("b_drain", valid_out_b, 0);
        fixed_sel_b = 3'd7;
        #1;
        check("b_oor_ready7", ready_out_b, 0);
        tick();
        check("b_idle", valid_out_b, 0);
        valid_b      = '0;
        fixed_mode_b = 1'b0;

        // Reset in the middle of a ch3 burst
        set_blen(3, 4);
        push(3, 0); push(3, 0);
        valid_in = 4'b1000;
        tick(); tick();
        rst_b = 1'b0;
        exp_q.delete();
        repeat (2) begin
            tick();
            check("mid_rst_valid", valid_out, 0);
            check("mid_rst_ready", ready_out, 0);
        end
        set_blen(3, 1);
        valid_in = 4'b1010;
        push(1, 1);
        rst_b = 1'b1;
        #1;
        check("post_rst_ready", ready_out, 4'b0010);
        tick();
        valid_in = '0;
        tick(); tick();
        check("post_rst_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
